// File: rtl/decoder_3x8_buffered_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3x8_buffered_if
// Purpose  : Bundles the code-input and one-hot-output handshakes of
//            decoder_3x8_buffered.
// Signals  : a,b,c      3-bit code (a = MSB, weight 4)
//            in_valid   producer presents a code
//            in_ready   decoder can accept a code
//            d0..d7     one-hot decoded lines (d0 <-> code 0)
//            out_valid  d0..d7 carry a decoded code
//            out_ready  consumer accepts the decoded code
//            xfer_cnt   completed output transfers, modulo 256
// Modports : slave  - decoder side
//            master - producer/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface decoder_3x8_buffered_if;
    logic       a;
    logic       b;
    logic       c;
    logic       in_valid;
    logic       in_ready;
    logic       d0;
    logic       d1;
    logic       d2;
    logic       d3;
    logic       d4;
    logic       d5;
    logic       d6;
    logic       d7;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] xfer_cnt;

    modport slave (
        input  a, b, c, in_valid, out_ready,
        output in_ready, d0, d1, d2, d3, d4, d5, d6, d7, out_valid, xfer_cnt
    );

    modport master (
        output a, b, c, in_valid, out_ready,
        input  in_ready, d0, d1, d2, d3, d4, d5, d6, d7, out_valid, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/decoder_3x8_buffered.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3x8_buffered
// Purpose  : Registered 3-to-8 decoder behind a 2-entry FIFO with valid/ready
//            handshakes on both sides and an 8-bit output-transfer counter.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - decoder_3x8_buffered_if.slave (code in, one-hot out,
//                     handshakes, xfer_cnt)
// Config   : DECODER_3X8_HOLD_EN - when defined, d0..d7 keep the last popped
//            code's one-hot value while out_valid = 0 (all zero after reset);
//            otherwise d0..d7 are zero whenever out_valid = 0.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_3x8_buffered (
    input  logic                         clk,
    input  logic                         rst_n,
    decoder_3x8_buffered_if.slave        bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [2:0] mem0_q, mem1_q;
    logic [7:0] xfer_q, xfer_d;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_code;
    logic [2:0] w_head;
    logic [7:0] w_head_onehot;
    logic [7:0] w_lines;

    // Handshake outputs come straight from the registered state.
    assign w_in_ready  = (state_q != FULL);
    assign w_out_valid = (state_q != EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_code      = {bus.a, bus.b, bus.c};

    assign w_head        = rd_ptr_q ? mem1_q : mem0_q;
    assign w_head_onehot = 8'd1 << w_head;

    // Next-state logic for occupancy and pointers.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        xfer_d   = xfer_q;

        if (w_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
            xfer_d   = xfer_q + 8'd1;
        end

        case (state_q)
            EMPTY: if (w_push)                state_d = ONE;
            ONE: begin
                if (w_push && !w_pop)         state_d = FULL;
                else if (w_pop && !w_push)    state_d = EMPTY;
            end
            FULL:  if (w_pop)                 state_d = ONE;
            default:                          state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            xfer_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            xfer_q   <= xfer_d;
        end
    end

    // Storage: the write pointer selects the slot; a push never targets the
    // head slot while it is occupied because in_ready is low when FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q <= 3'd0;
            mem1_q <= 3'd0;
        end else if (w_push) begin
            if (wr_ptr_q) mem1_q <= w_code;
            else          mem0_q <= w_code;
        end
    end

`ifdef DECODER_3X8_HOLD_EN
    logic [7:0] last_q;

    // Remember the one-hot value of each code as it leaves the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 8'd0;
        end else if (w_pop) begin
            last_q <= w_head_onehot;
        end
    end

    assign w_lines = w_out_valid ? w_head_onehot : last_q;
`else
    assign w_lines = w_out_valid ? w_head_onehot : 8'd0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.xfer_cnt  = xfer_q;
    assign bus.d0        = w_lines[0];
    assign bus.d1        = w_lines[1];
    assign bus.d2        = w_lines[2];
    assign bus.d3        = w_lines[3];
    assign bus.d4        = w_lines[4];
    assign bus.d5        = w_lines[5];
    assign bus.d6        = w_lines[6];
    assign bus.d7        = w_lines[7];

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3x8_buffered
// Purpose  : Self-checking bench for decoder_3x8_buffered. Expected codes are
//            queued when accepted and compared by an independent monitor.
// Config   : honours DECODER_3X8_HOLD_EN for the idle-line expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_3x8_buffered;

    logic clk;
    logic rst_n;
    decoder_3x8_buffered_if intf ();

    decoder_3x8_buffered dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents are simply the accepted codes in order.
    int         ref_q[$];
    logic [7:0] exp_xfer  = 8'd0;
    logic [7:0] exp_last  = 8'd0;
    logic       stall_seen = 1'b0;
    logic [7:0] stall_d    = 8'd0;
    int         out_mode   = 1;   // 0 random, 1 always ready, 2 never ready

    function automatic logic [7:0] lines();
        return {intf.d7, intf.d6, intf.d5, intf.d4,
                intf.d3, intf.d2, intf.d1, intf.d0};
    endfunction

    function automatic logic [7:0] idle_lines();
`ifdef DECODER_3X8_HOLD_EN
        return exp_last;
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer readiness, changed shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        case (out_mode)
            0:       intf.out_ready = 1'($urandom_range(0, 1));
            1:       intf.out_ready = 1'b1;
            default: intf.out_ready = 1'b0;
        endcase
    end

    // Monitor: samples on the falling edge, when inputs and outputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  {31'd0, intf.in_ready},  {31'd0, ref_q.size() != 2});
            chk("out_valid", {31'd0, intf.out_valid}, {31'd0, ref_q.size() != 0});
            chk("xfer_cnt",  {24'd0, intf.xfer_cnt},  {24'd0, exp_xfer});
            if (ref_q.size() != 0) chk("d_head", {24'd0, lines()}, {24'd0, 8'd1 << ref_q[0]});
            else                   chk("d_idle", {24'd0, lines()}, {24'd0, idle_lines()});
            if (stall_seen) begin
                chk("stable_valid", {31'd0, intf.out_valid}, 32'd1);
                chk("stable_d",     {24'd0, lines()},        {24'd0, stall_d});
            end
            stall_seen = intf.out_valid && !intf.out_ready;
            stall_d    = lines();
            if (ref_q.size() != 0 && intf.out_ready) begin
                exp_last = 8'd1 << ref_q.pop_front();
                exp_xfer = exp_xfer + 8'd1;
            end
        end
    end

    // Present one code and hold it until accepted (entered at posedge+1).
    task automatic send_code(input int code);
        bit acc;
        intf.in_valid = 1'b1;
        {intf.a, intf.b, intf.c} = 3'(code);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk); #1;
            acc = intf.in_ready;
            if (acc) ref_q.push_back(code);
            @(posedge clk); #1;
            if (acc) begin
                intf.in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'd1, 32'd0);
        intf.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 1000; n++) begin
            if (ref_q.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b1;
        {intf.a, intf.b, intf.c} = 3'd0;
        idle(2);
        rst_n = 1'b1;

        // Reset state with no stimulus.
        idle(3);
        chk("rst_d",        {24'd0, lines()},        32'd0);
        chk("rst_out_valid",{31'd0, intf.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, intf.in_ready},  32'd1);
        chk("rst_xfer",     {24'd0, intf.xfer_cnt},  32'd0);

        // Back-to-back sweep with a willing consumer.
        out_mode = 1;
        for (int k = 0; k < 8; k++) send_code(k);
        drain();
        chk("sweep_xfer", {24'd0, intf.xfer_cnt}, 32'd8);

        // Backpressure: 3 and 5 buffered, 6 stalls until the consumer wakes.
        out_mode = 2;
        fork
            begin
                send_code(3);
                send_code(5);
                send_code(6);
            end
            begin
                idle(6);
                chk("bp_full_in_ready", {31'd0, intf.in_ready}, 32'd0);
                chk("bp_head_d3",       {24'd0, lines()},       32'h08);
                out_mode = 1;
            end
        join
        drain();

        // Randomized traffic with random consumer readiness.
        out_mode = 0;
        for (int k = 0; k < 150; k++) begin
            send_code(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        out_mode = 1;
        drain();

        // Fill the buffer, then reset between clock edges.
        out_mode = 2;
        send_code(1);
        send_code(4);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, intf.out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, intf.in_ready},  32'd1);
        chk("arst_d",         {24'd0, lines()},        32'd0);
        chk("arst_xfer",      {24'd0, intf.xfer_cnt},  32'd0);
        ref_q.delete();
        exp_xfer   = 8'd0;
        exp_last   = 8'd0;
        stall_seen = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        out_mode = 1;
        send_code(7);
        drain();
        chk("post_rst_xfer", {24'd0, intf.xfer_cnt}, 32'd1);

        // Counter wrap: 256 transfers since reset, then one more.
        for (int k = 0; k < 255; k++) send_code(int'($urandom_range(0, 7)));
        drain();
        chk("wrap_zero", {24'd0, intf.xfer_cnt}, 32'd0);
        send_code(2);
        drain();
        chk("wrap_one", {24'd0, intf.xfer_cnt}, 32'd1);

        // Idle after popping code 2.
        idle(3);
`ifdef DECODER_3X8_HOLD_EN
        chk("idle_hold_d2", {24'd0, lines()}, 32'h04);
`else
        chk("idle_zero_d",  {24'd0, lines()}, 32'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
